// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Power-on / manual reset sequencer with a free-running system tick.
//   After nrst or a (debounced) manual request, every domain is held in
//   reset for HOLD_TICKS ticks, then domains are released one at a time,
//   STAGGER_TICKS ticks apart, domain 0 first.
//
//   Optional feature macro: RESET_SEQ_WDOG_EN
//     defined   -> watchdog in RUN re-runs the sequence if not kicked
//                  within WDOG_TICKS ticks; wdog_fired is sticky.
//     undefined -> kick ignored, wdog_fired tied low.
//
// Ports
//   clk         in   system clock
//   nrst        in   async active-low reset
//   manual_req  in   raw async manual reset request (active-high)
//   kick        in   watchdog kick, 1-cycle pulse, clk-synchronous
//   tick        out  1-cycle pulse at TICK_HZ
//   rst_out     out  per-domain active-high resets
//   seq_done    out  all domains released
//   wdog_fired  out  sticky: watchdog has forced a re-sequence
module reset_sequencer #(
    parameter int CLK_HZ        = 12_000_000,
    parameter int TICK_HZ       = 100,
    parameter int HOLD_TICKS    = 4,
    parameter int NUM_DOMAINS   = 2,
    parameter int STAGGER_TICKS = 1,
    parameter int WDOG_TICKS    = 200
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   manual_req,
    input  logic                   kick,
    output logic                   tick,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   seq_done,
    output logic                   wdog_fired
);

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int DW     = $clog2(DIV);
    localparam int RUN_AT = HOLD_TICKS + (NUM_DOMAINS - 1) * STAGGER_TICKS;
    localparam int TW     = $clog2(RUN_AT + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] HOLD_C   = TW'(HOLD_TICKS);
    localparam logic [TW-1:0] RUN_C    = TW'(RUN_AT);

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

    state_t                 state, state_nxt;
    logic [DW-1:0]          div_cnt;
    logic [TW-1:0]          tick_cnt, cnt_nxt, cnt_inc;
    logic                   man_meta, man_s;
    logic                   wd_timeout;
    logic [NUM_DOMAINS-1:0] rst_nxt;

    // Free-running prescaler; only nrst touches it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    // Two-flop synchroniser for the raw manual request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            man_meta <= 1'b0;
            man_s    <= 1'b0;
        end else begin
            man_meta <= manual_req;
            man_s    <= man_meta;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_HOLD;
            tick_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= cnt_nxt;
        end
    end

    // A held man_s keeps clearing tick_cnt, which doubles as the debounce:
    // release only begins after HOLD_TICKS ticks with the request quiet.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = tick_cnt;
        cnt_inc   = (tick_cnt == RUN_C) ? tick_cnt : tick_cnt + TW'(1);
        unique case (state)
            S_HOLD: begin
                if (man_s) begin
                    cnt_nxt = '0;
                end else if (tick) begin
                    cnt_nxt = cnt_inc;
                    // RUN_AT == HOLD_TICKS when there is nothing to stagger
                    if (cnt_inc == RUN_C)       state_nxt = S_RUN;
                    else if (cnt_inc >= HOLD_C) state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (man_s) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == RUN_C) state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (man_s || wd_timeout) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_HOLD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode from next state / next count so they move on the
    // same edge as the FSM.
    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        localparam logic [TW-1:0] THR = TW'(HOLD_TICKS + g * STAGGER_TICKS);
        assign rst_nxt[g] = (state_nxt == S_HOLD) || (cnt_nxt < THR);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rst_out  <= '1;
            seq_done <= 1'b0;
        end else begin
            rst_out  <= rst_nxt;
            seq_done <= (state_nxt == S_RUN);
        end
    end

`ifdef RESET_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_TICKS + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_TICKS - 1);

    logic [WW-1:0] wd_cnt;

    // A kick on the timeout tick wins.
    assign wd_timeout = (state == S_RUN) && tick && !kick && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_cnt     <= '0;
            wdog_fired <= 1'b0;
        end else begin
            if (state_nxt != S_RUN || kick)   wd_cnt <= '0;
            else if (state == S_RUN && tick)  wd_cnt <= wd_cnt + WW'(1);
            if (wd_timeout && !man_s)         wdog_fired <= 1'b1;
        end
    end
`else
    localparam int unused_wdog_ticks = WDOG_TICKS;
    logic unused_kick;

    assign unused_kick = kick;
    assign wd_timeout  = 1'b0;
    assign wdog_fired  = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int ND = 3;
`ifdef RESET_SEQ_WDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic          manual_req;
    logic          kick;
    logic          kick_en;
    logic          tick;
    logic [ND-1:0] rst_out;
    logic          seq_done;
    logic          wdog_fired;

    int total = 0;
    int bad   = 0;
    int cyc;

    typedef struct {
        int          c;
        logic [ND-1:0] r;
        logic        d;
        logic        w;
    } exp_t;

    exp_t q[$];

    reset_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .HOLD_TICKS(4), .NUM_DOMAINS(ND),
        .STAGGER_TICKS(2), .WDOG_TICKS(5)
    ) dut (
        .clk(clk), .nrst(nrst), .manual_req(manual_req), .kick(kick),
        .tick(tick), .rst_out(rst_out), .seq_done(seq_done), .wdog_fired(wdog_fired)
    );

    always #5 clk = ~clk;

    // cycle 1 = first rising edge with nrst high
    always @(posedge clk or negedge nrst) begin
        if (!nrst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [ND-1:0] r, input logic d, input logic w);
        exp_t e;
        e.c = c; e.r = r; e.d = d; e.w = w;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc != n && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            total++; bad++;
            $display("FAIL wait_cyc: got cyc %0d want %0d", cyc, n);
        end
    endtask

    // Periodic kicker: one kick every 3 ticks while enabled.
    initial begin
        kick = 1'b0;
        forever begin
            @(negedge clk);
            kick = kick_en && (cyc % 30 == 5);
        end
    end

    // Monitor: every change of the output bundle pops one expected record.
    initial begin : monitor
        logic [ND+1:0] last, cur;
        last = {3'b111, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (tick === 1'b1) chk("tick_phase", cyc % 10, 0);
            cur = {rst_out, seq_done, wdog_fired};
            if (cur !== last) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_change: got %b at cyc %0d want none", cur, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_value", {27'd0, cur}, {27'd0, e.r, e.d, e.w});
                    chk("out_cycle", cyc, e.c);
                end
                last = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got time %0t want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 1'b1; manual_req = 1'b0; kick_en = 1'b1;

        // power-on
        push(41, 3'b110, 0, 0); push(61, 3'b100, 0, 0); push(81, 3'b000, 1, 0);
        // manual request in RUN
        push(103, 3'b111, 0, 0); push(141, 3'b110, 0, 0);
        push(161, 3'b100, 0, 0); push(181, 3'b000, 1, 0);
        // bouncing request, then collision with domain-1 release
        push(203, 3'b111, 0, 0); push(281, 3'b110, 0, 0); push(301, 3'b111, 0, 0);
        push(341, 3'b110, 0, 0); push(361, 3'b100, 0, 0); push(381, 3'b000, 1, 0);
`ifdef RESET_SEQ_WDOG_EN
        push(431, 3'b111, 0, 1); push(471, 3'b110, 0, 1);
        push(491, 3'b100, 0, 1); push(511, 3'b000, 1, 1);
`endif
        // manual into RELEASE, then async nrst, then power-on again
        push(623, 3'b111, 0, WD); push(661, 3'b110, 0, WD);
        push(0, 3'b111, 0, 0);
        push(41, 3'b110, 0, 0); push(61, 3'b100, 0, 0); push(81, 3'b000, 1, 0);

        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rst_out", rst_out, 3'b111);
        chk("reset_tick", tick, 0);
        chk("reset_seq_done", seq_done, 0);
        chk("reset_wdog", wdog_fired, 0);
        nrst = 1'b1;

        wait_cyc(100); manual_req = 1'b1;
        wait_cyc(103); manual_req = 1'b0;

        wait_cyc(200); manual_req = 1'b1;
        wait_cyc(215); manual_req = 1'b0;
        wait_cyc(230); manual_req = 1'b1;
        wait_cyc(245); manual_req = 1'b0;

        wait_cyc(298); manual_req = 1'b1;
        wait_cyc(301); manual_req = 1'b0;

        wait_cyc(385); kick_en = 1'b0;
        wait_cyc(512); kick_en = 1'b1;
        wait_cyc(600); chk("wdog_fired_sticky", wdog_fired, WD);

        wait_cyc(620); manual_req = 1'b1;
        wait_cyc(621); manual_req = 1'b0;

        wait_cyc(670);
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_out", rst_out, 3'b111);
        chk("async_seq_done", seq_done, 0);
        chk("async_tick", tick, 0);
        chk("async_wdog", wdog_fired, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        wait_cyc(100);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on/manual reset sequencer and system tick generator for the iCE40 board top level. It generalises the fixed 100 Hz divider and the 3-bit startup reset into one block. The block produces a free-running tick at TICK_HZ and NUM_DOMAINS active-high reset outputs. After power-up or a manual reset request, the reset outputs are held for a programmable number of ticks and then released one domain at a time. An optional watchdog re-runs the sequence when it is not kicked.

## Interface
Parameters:
- CLK_HZ, 12_000_000: frequency of `clk`.
- TICK_HZ, 100: tick rate. DIV = CLK_HZ/TICK_HZ, which must be ≥ 2.
- HOLD_TICKS, 4: number of ticks all domains are held in reset. Must be ≥ 1.
- NUM_DOMAINS, 2: number of reset outputs. Must be ≥ 1.
- STAGGER_TICKS, 1: ticks between the release of consecutive domains. May be 0.
- WDOG_TICKS, 200: watchdog timeout in ticks. Used only with the macro defined.

Ports:
- clk  in  1  system clock (hwclk domain).
- nrst  in  1  reset, asynchronous, active-low.
- manual_req  in  1  raw, asynchronous manual reset request, active-high (for example a button combination).
- kick  in  1  watchdog kick, synchronous to `clk`, 1-cycle pulse.
- tick  out  1  1-cycle pulse at TICK_HZ.
- rst_out  out  NUM_DOMAINS  per-domain reset, active-high. Domain 0 is released first.
- seq_done  out  1  high when every domain has been released.
- wdog_fired  out  1  sticky flag: the watchdog has triggered a re-sequence.

## Operation
- Prescaler: `div_cnt` counts 0..DIV-1 and wraps. The registered `tick` is 1 in the cycle after `div_cnt` == DIV-1. The prescaler is free-running and is never cleared by `manual_req` or by the watchdog.
- Synchroniser: `manual_req` passes through a 2-flop synchroniser; the synchronised signal is `man_s`.
- `tick_cnt` counts ticks. It saturates at RUN_AT = HOLD_TICKS + (NUM_DOMAINS-1)*STAGGER_TICKS. Its width is $clog2(RUN_AT+1).
- FSM states:
  - HOLD:
    - All `rst_out` = 1 and `seq_done` = 0.
    - `tick_cnt` increments on each `tick` while `man_s` = 0.
    - `man_s` = 1 clears `tick_cnt` to 0. This debounces the request: release starts only after HOLD_TICKS clean ticks.
    - Go to RELEASE when `tick_cnt` reaches HOLD_TICKS.
  - RELEASE:
    - `rst_out[i]` = 0 once `tick_cnt` ≥ HOLD_TICKS + i*STAGGER_TICKS.
    - `tick_cnt` keeps counting.
    - Go to RUN when `tick_cnt` == RUN_AT.
    - If `man_s` = 1, go to HOLD, clear `tick_cnt` and reassert all `rst_out`.
  - RUN:
    - All `rst_out` = 0 and `seq_done` = 1.
    - `man_s` = 1 goes to HOLD and clears `tick_cnt`.
- `rst_out` and `seq_done` are registered and are decoded from the next state and next `tick_cnt`. An output therefore changes on the same edge that updates the state.
- When STAGGER_TICKS = 0, all domains release together when `tick_cnt` reaches HOLD_TICKS.

## Timing
- While `nrst` = 0 (asynchronous):
  - `div_cnt` = 0, `tick` = 0, `tick_cnt` = 0, state = HOLD.
  - `rst_out` = all ones, `seq_done` = 0, `wdog_fired` = 0.
  - Both synchroniser flops = 0.
- First `tick`: cycle DIV after `nrst` rises, counting the first rising edge with `nrst` high as cycle 1. Later ticks follow every DIV cycles.
- `rst_out[i]` falls on the edge that samples the (HOLD_TICKS + i*STAGGER_TICKS)-th tick. `seq_done` rises on the same edge as `rst_out[NUM_DOMAINS-1]` falls.
- Manual request: `man_s` is high 2 edges after `manual_req` rises. All `rst_out` reassert 1 edge later, i.e. 3 edges after `manual_req`.
- A manual request in the same cycle as a release: the manual request wins, and no domain releases.
- `nrst` asserted mid-sequence: outputs return to their reset values immediately (asynchronously).

## Configuration
- `RESET_SEQ_WDOG_EN` defined:
  - In RUN, a watchdog counter counts ticks. `kick` = 1 clears it.
  - When the count reaches WDOG_TICKS, the FSM goes to HOLD, `tick_cnt` is cleared, and `wdog_fired` is set.
  - `wdog_fired` is cleared only by `nrst`.
  - The watchdog counter is held at 0 outside RUN.
  - A `kick` in the same cycle as the timeout tick prevents the timeout.
- `RESET_SEQ_WDOG_EN` not defined: `kick` is ignored, `wdog_fired` is tied to 0, and no watchdog logic is built. The port list is identical in both builds.

## Test plan
Sim parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), HOLD_TICKS=4, NUM_DOMAINS=3, STAGGER_TICKS=2, WDOG_TICKS=5. Cycle 1 is the first rising edge with `nrst` high.
- Power-on:
  - `nrst` low → `rst_out`=3'b111, `tick`=0, `seq_done`=0.
  - Release `nrst` → `tick` high at cycles 10, 20, 30…
  - `rst_out` becomes 3'b110 at the 4th tick, 3'b100 at the 6th, 3'b000 at the 8th. `seq_done` = 1 at the 8th tick.
- Manual request in RUN: pulse `manual_req` high for 3 cycles → `rst_out`=3'b111 three edges later. Release resumes 4 ticks after `man_s` falls.
- Bouncing request: toggle `manual_req` every 15 cycles during HOLD → `tick_cnt` keeps clearing and `rst_out` stays 3'b111. After the last bounce, domain 0 releases at exactly the 4th tick.
- Manual request during RELEASE, at the same edge as domain 1 would release → `rst_out` goes 3'b110 → 3'b111, and domain 1 never deasserts.
- Watchdog (with `RESET_SEQ_WDOG_EN`):
  - No `kick` for 5 ticks in RUN → `rst_out`=3'b111 and `wdog_fired`=1 is held.
  - With a `kick` every 3 ticks → no re-sequence.
  - Without the macro, the same stimulus leaves `wdog_fired`=0.
- `nrst` pulse mid-RELEASE → `rst_out`=3'b111 within the same cycle, and the prescaler restarts from 0.
